// File: rtl/spi_word_framer.sv
// spi_word_framer: SPI mode-0 target front end. It turns oversampled SCK/CS/COPI
// pins into little-endian command words and shifts reply words out on CIPO.
//   CLK, resetn          system clock, asynchronous active-low reset
//   SCK, CS, COPI        raw SPI pins from the host (CS active low)
//   CIPO                 reply data to the host, 0 while deselected
//   word_send_data       reply word, snapshotted at CS fall and at each word boundary
//   word_data_received   last complete received word
//   word_received        one-CLK pulse per complete word
//   word_aborted         one-CLK pulse when CS rises mid-word
//   cs_active            synchronized chip select, asserted high
module spi_word_framer #(
    parameter int WORD_BITS   = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 resetn,
    input  logic                 SCK,
    input  logic                 CS,
    input  logic                 COPI,
    output logic                 CIPO,
    input  logic [WORD_BITS-1:0] word_send_data,
    output logic [WORD_BITS-1:0] word_data_received,
    output logic                 word_received,
    output logic                 word_aborted,
    output logic                 cs_active
);
    localparam int CW = $clog2(WORD_BITS);
    localparam logic [WORD_BITS-1:0] LOW_BYTE = WORD_BITS'(8'hFF);
    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, copi_sync_q;
    logic                   sck_prev_q, cs_prev_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WORD_BITS-1:0]   rx_q, rx_d, tx_q, tx_d, wdr_q, wdr_d;
    logic                   wr_q, wr_d, wa_q, wa_d;
    logic                   sck_s, cs_s, copi_s, sck_rise, sck_fall, cs_rise, cs_fall;
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign copi_s   = copi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_active          = ~cs_s;
    assign CIPO               = cs_active & tx_q[7];
    assign word_data_received = wdr_q;
    assign word_received      = wr_q;
    assign word_aborted       = wa_q;
    // CS edges take priority over SCK edges landing in the same cycle.
    // Received bit n goes to byte n/8, MSB first: index = n with its low three bits inverted.
    // The tx low byte shifts left so CIPO always shows tx_q[7]. After each full byte the
    // whole word moves down by eight, which brings the next untouched byte into place.
    always_comb begin
        rx_d  = rx_q;
        tx_d  = tx_q;
        cnt_d = cnt_q;
        wdr_d = wdr_q;
        wr_d  = 1'b0;
        wa_d  = 1'b0;
        if (cs_fall) begin
            tx_d  = word_send_data;
            cnt_d = '0;
            rx_d  = '0;
        end else if (cs_rise) begin
            wa_d  = cnt_q != '0;
            cnt_d = '0;
            rx_d  = '0;
        end else if (cs_active && sck_rise) begin
            rx_d[cnt_q ^ CW'(7)] = copi_s;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WORD_BITS - 1)) begin
                cnt_d = '0;
                wdr_d = rx_d;
                wr_d  = 1'b1;
                tx_d  = word_send_data;
            end
        end else if (cs_active && sck_fall && cnt_q != '0) begin
            tx_d = (cnt_q[2:0] == 3'd0) ? tx_q >> 8 : (tx_q & ~LOW_BYTE) | ((tx_q << 1) & LOW_BYTE);
        end
    end
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            copi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            wdr_q       <= '0;
            wr_q        <= 1'b0;
            wa_q        <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], COPI};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            wdr_q       <= wdr_d;
            wr_q        <= wr_d;
            wa_q        <= wa_d;
        end
    end
endmodule

// File: tb/tb_spi_word_framer.sv
// tb_spi_word_framer: randomized and directed checks of spi_word_framer against a bit-level wire model.
module tb_spi_word_framer;
    logic        CLK = 0, resetn = 0, SCK = 0, CS = 1, COPI = 0;
    logic        CIPO, wr, wa, csa;
    logic [63:0] wsd = '0, wdr;
    int          errors = 0, checks = 0, ab_cnt = 0, pulse_err = 0;
    logic [63:0] rxq[$];
    logic [63:0] exp_last = '0;
    logic        wr_prev = 0, wa_prev = 0, r;
    time         t_rise = 0;
    int          n0, a0, kind;
    logic [127:0] d;

    always #5 CLK = ~CLK;

    spi_word_framer dut (
        .CLK(CLK), .resetn(resetn), .SCK(SCK), .CS(CS), .COPI(COPI), .CIPO(CIPO),
        .word_send_data(wsd), .word_data_received(wdr), .word_received(wr),
        .word_aborted(wa), .cs_active(csa)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Wire bit i of a word: byte i/8, MSB first.
    function automatic int pos(input int i);
        return 8 * (i / 8) + 7 - i % 8;
    endfunction

    task automatic send_bit(input logic b, output logic rb);
        COPI = b;
        clks(8);
        rb = CIPO;
        SCK = 1;
        clks(8);
        SCK = 0;
    endtask

    // One CS window of nbits; reply source switches to s1 at bit 10.
    task automatic frame(input logic [127:0] dd, input logic [63:0] s0, input logic [63:0] s1, input int nbits);
        int fn0 = rxq.size(), fa0 = ab_cnt, nw = nbits / 64;
        logic [127:0] rep = '0;
        logic rb;
        wsd = s0;
        CS = 0;
        clks(6);
        for (int i = 0; i < nbits; i++) begin
            if (i == 10) wsd = s1;
            send_bit(dd[64 * (i / 64) + pos(i % 64)], rb);
            rep[64 * (i / 64) + pos(i % 64)] = rb;
        end
        CS = 1;
        clks(8);
        chk("words", 64'(rxq.size() - fn0), 64'(nw));
        chk("aborts", 64'(ab_cnt - fa0), 64'((nbits % 64) != 0));
        for (int w = 0; w < nw; w++) begin
            if (fn0 + w < rxq.size()) chk("rx_word", rxq[fn0 + w], dd[64 * w +: 64]);
            chk("reply", rep[64 * w +: 64], w == 0 ? s0 : s1);
            exp_last = dd[64 * w +: 64];
        end
        chk("held", wdr, exp_last);
    endtask

    always @(posedge SCK) t_rise = $time;

    // Pulse collector; word_received must follow the last raw SCK rise by 3 CLK (plus half-cycle sample).
    always @(negedge CLK) if (resetn) begin
        if (wr) begin
            rxq.push_back(wdr);
            chk("latency", 64'($time - t_rise), 64'(34));
        end
        if (wa) ab_cnt++;
        if ((wr && wr_prev) || (wa && wa_prev)) pulse_err++;
        wr_prev = wr;
        wa_prev = wa;
    end

    initial begin
        clks(3);
        chk("rst_wdr", wdr, 0);
        chk("rst_wr", 64'(wr), 0);
        chk("rst_wa", 64'(wa), 0);
        chk("rst_csa", 64'(csa), 0);
        chk("rst_cipo", 64'(CIPO), 0);
        resetn = 1;
        clks(3);
        frame({64'h0, 64'h0807060504030201}, 64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D, 64);
        frame({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 64'h1111111111111111, 128);
        frame({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 20);
        frame({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 64);
        wsd = {$urandom, $urandom};
        CS = 0;
        clks(6);
        for (int i = 0; i < 30; i++) send_bit(1'($urandom), r);
        resetn = 0;
        #1;
        chk("mid_rst_wdr", wdr, 0);
        chk("mid_rst_wr", 64'(wr), 0);
        chk("mid_rst_csa", 64'(csa), 0);
        chk("mid_rst_cipo", 64'(CIPO), 0);
        CS = 1;
        clks(4);
        exp_last = '0;
        resetn = 1;
        clks(4);
        frame({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 64);
        n0 = rxq.size();
        a0 = ab_cnt;
        for (int i = 0; i < 10; i++) begin
            SCK = 1;
            clks(4);
            chk("idle_cipo", 64'(CIPO), 0);
            SCK = 0;
            clks(4);
        end
        clks(6);
        chk("idle_words", 64'(rxq.size() - n0), 0);
        chk("idle_aborts", 64'(ab_cnt - a0), 0);
        frame({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 64);
        for (int k = 0; k < 10; k++) begin
            kind = $urandom_range(0, 2);
            d = {$urandom, $urandom, $urandom, $urandom};
            frame(d, {$urandom, $urandom}, {$urandom, $urandom},
                  kind == 0 ? 64 : kind == 1 ? 128 : int'($urandom_range(1, 63)));
        end
        chk("pulse_width", 64'(pulse_err), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_word_framer.md
Name: spi_word_framer

Overview:
- SPI target front end: converts the raw SCK/CS/COPI/CIPO pins into 64-bit little-endian command words for the SPI state machine.
- Returns 64-bit reply words from the state machine on CIPO.
- Runs entirely in the system clock domain. SPI pins are oversampled through synchronizers.
- Sits directly upstream of the SPI state machine, between the top-level pins and its word_data_received / word_received / word_send_data interface.

Parameters:
- WORD_BITS, 64, bits per word; must be a multiple of 8.
- SYNC_STAGES, 2, synchronizer flops on SCK, CS and COPI; minimum 2.

Ports:
- CLK  input  1  system clock; f_CLK must be at least 8x f_SCK.
- resetn  input  1  asynchronous, active-low reset.
- SCK  input  1  SPI clock from host, mode 0 (CPOL=0, CPHA=0).
- CS  input  1  chip select, active low.
- COPI  input  1  controller-out data.
- CIPO  output  1  controller-in data.
- word_send_data  input  WORD_BITS  reply word, snapshotted at each word boundary.
- word_data_received  output  WORD_BITS  last complete received word.
- word_received  output  1  one-CLK pulse per complete word.
- word_aborted  output  1  one-CLK pulse when CS deasserts with a partial word.
- cs_active  output  1  synchronized CS asserted.

Behaviour:
- Reset (async assert, sync release): all of the following are 0 — outputs, word_data_received, shift registers, bit counter. Synchronizers reset to idle: SCK=0, CS=1, COPI=0.
- Synchronization:
  - SCK, CS and COPI each pass through SYNC_STAGES flops.
  - Rise/fall detection compares the last synchronized stage with one extra history flop.
  - COPI is delayed by the same depth as SCK, so it is sampled consistently with SCK.
- Bit counter: log2(WORD_BITS) bits, range 0..WORD_BITS-1.
- Receive:
  - On each synced SCK rising edge while cs_active=1: shift COPI into the rx register and increment the counter.
  - Bit order: MSB-first within each byte; first byte on the wire lands in word[7:0], byte k lands in word[8k+7:8k].
- Word completion, on the rising edge that samples bit WORD_BITS-1:
  - The counter wraps to 0.
  - word_data_received updates in the same cycle that word_received pulses.
  - word_data_received then holds until the next complete word.
  - word_received is high for exactly one CLK.
  - The tx register reloads from word_send_data.
- Transmit:
  - On synced CS falling edge: tx register loads word_send_data and the counter clears.
  - CIPO presents bit 7 of the snapshot before the first SCK rise.
  - On synced SCK falling edge with counter != 0: tx advances to the next bit in the same byte/bit order as receive.
  - On the falling edge that follows the wrap (counter = 0): no shift, so bit 7 of the new snapshot stays on CIPO.
  - CIPO = 0 whenever cs_active = 0.
  - Changes to word_send_data mid-word have no effect until the next reload.
- CS deassert with counter != 0: partial data is discarded, counter→0, word_aborted pulses one CLK, no word_received.
- CS deassert with counter = 0: no pulse.
- SCK edges while cs_active = 0 are ignored.
- Simultaneous events:
  - Synced CS rise and SCK rise in the same CLK: the CS rise wins; the bit is not sampled.
  - Synced CS fall and SCK edge in the same CLK: the SCK edge is ignored.
- Back-to-back words under a single CS assertion are supported without gaps. Every 64 bits produces one word_received.
- Latency: word_received asserts SYNC_STAGES+1 CLK cycles after the final raw SCK rise.
- Reset asserted mid-word: immediate clear. After release, the framer waits for a fresh CS falling edge.

Test Plan:
- Single word: CS low, send bytes 0x01..0x08 MSB-first, CS high -> one word_received pulse, word_data_received=0x0807060504030201, word_aborted=0.
- Reply path: word_send_data=0xDEADBEEFCAFEF00D before CS fall -> CIPO emits bytes 0x0D,0xF0,0xFE,0xCA,0xEF,0xBE,0xAD,0xDE MSB-first; first bit (0) valid before first SCK rise.
- Back-to-back: 128 SCK clocks in one CS window; word_send_data changed to 0x1111111111111111 mid-first-word -> two word_received pulses; second reply word = 0x1111111111111111; first reply unaffected.
- Abort: CS high after 20 bits -> word_aborted pulses once, no word_received, word_data_received unchanged; next full word decodes correctly.
- Reset mid-word: resetn low after 30 bits, then a full word -> all outputs 0 during reset; post-reset word decodes correctly with exactly one pulse.
- Idle glitches: SCK toggled 10 times with CS high -> no pulses, CIPO=0, counter stays 0.
